// File: rtl/slice_mux.sv
// Round-robin slice chunk interleaver packing byte-contiguous chunks into a 256-bit output stream.
// Optional PPS prefix words are enabled by defining SLICE_MUX_PPS_EN.
module slice_mux #(
  parameter int unsigned MAX_NBR_SLICES  = 2,
  parameter int unsigned MAX_SLICE_WIDTH = 2560
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [9:0]                      slices_per_line,
  input  logic [15:0]                     chunk_size,
  input  logic [15:0]                     chunks_per_slice,
  input  logic                            frame_start,
  input  logic [256*MAX_NBR_SLICES-1:0]   in_data_p,
  input  logic [MAX_NBR_SLICES-1:0]       in_valid,
  output logic [MAX_NBR_SLICES-1:0]       in_ready,
  input  logic [1023:0]                   in_pps,
  output logic [255:0]                    out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sof,
  output logic                            out_last,
  output logic                            data_out_is_pps
);

  localparam int unsigned AW    = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;
  localparam int unsigned WBITS = 256;
  localparam int unsigned ABITS = 512;

  typedef enum logic [1:0] {S_IDLE, S_PPS, S_CHUNK, S_TAIL} state_t;

  state_t            state, state_nxt;
  logic [ABITS-1:0]  acc, acc_nxt;
  logic [6:0]        acc_cnt, acc_cnt_nxt;
  logic [AW-1:0]     active, active_nxt;
  logic [15:0]       chunk_idx, chunk_idx_nxt;
  logic [15:0]       bytes_left, bytes_left_nxt;
  logic              sof_pending, sof_pending_nxt;

`ifdef SLICE_MUX_PPS_EN
  logic [1023:0]     pps_q, pps_nxt;
  logic [1:0]        pps_cnt, pps_cnt_nxt;
  logic              unused_ok;
  assign unused_ok = 1'(MAX_SLICE_WIDTH);
`else
  logic              unused_ok;
  assign unused_ok = ^{in_pps, 1'(MAX_SLICE_WIDTH)};
`endif

  logic              cfg_ok;
  logic              emit, accept, in_rdy, sel_valid;
  logic [5:0]        n;
  logic [6:0]        cnt_sh;
  logic [ABITS-1:0]  acc_sh, ins;
  logic [WBITS-1:0]  sel_word, mask;

  assign cfg_ok = (slices_per_line != 10'd0) && (slices_per_line <= 10'(MAX_NBR_SLICES)) &&
                  (chunk_size != 16'd0) && (chunks_per_slice != 16'd0);

  // Select the active slice's input word.
  always_comb begin
    sel_word  = '0;
    sel_valid = 1'b0;
    for (int s = 0; s < int'(MAX_NBR_SLICES); s++) begin
      if (active == AW'(s)) begin
        sel_word  = in_data_p[s*WBITS +: WBITS];
        sel_valid = in_valid[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state       <= S_IDLE;
      acc         <= '0;
      acc_cnt     <= '0;
      active      <= '0;
      chunk_idx   <= '0;
      bytes_left  <= '0;
      sof_pending <= 1'b0;
`ifdef SLICE_MUX_PPS_EN
      pps_q       <= '0;
      pps_cnt     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      acc_cnt     <= acc_cnt_nxt;
      active      <= active_nxt;
      chunk_idx   <= chunk_idx_nxt;
      bytes_left  <= bytes_left_nxt;
      sof_pending <= sof_pending_nxt;
`ifdef SLICE_MUX_PPS_EN
      pps_q       <= pps_nxt;
      pps_cnt     <= pps_cnt_nxt;
`endif
    end
  end

  // Next-state, accumulator update and handshake outputs.
  always_comb begin
    state_nxt       = state;
    acc_nxt         = acc;
    acc_cnt_nxt     = acc_cnt;
    active_nxt      = active;
    chunk_idx_nxt   = chunk_idx;
    bytes_left_nxt  = bytes_left;
    sof_pending_nxt = sof_pending;
`ifdef SLICE_MUX_PPS_EN
    pps_nxt         = pps_q;
    pps_cnt_nxt     = pps_cnt;
`endif
    out_valid = 1'b0;
    out_last  = 1'b0;
    emit      = 1'b0;
    accept    = 1'b0;
    in_rdy    = 1'b0;
    n         = (bytes_left >= 16'd32) ? 6'd32 : 6'(bytes_left);
    mask      = ~({WBITS{1'b1}} << {n, 3'b000});
    acc_sh    = acc;
    cnt_sh    = acc_cnt;
    ins       = '0;

    case (state)
      S_IDLE: begin
        if (frame_start && cfg_ok) begin
          active_nxt      = '0;
          chunk_idx_nxt   = '0;
          bytes_left_nxt  = chunk_size;
          sof_pending_nxt = 1'b1;
          acc_nxt         = '0;
          acc_cnt_nxt     = '0;
`ifdef SLICE_MUX_PPS_EN
          state_nxt       = S_PPS;
          pps_nxt         = in_pps;
          pps_cnt_nxt     = '0;
`else
          state_nxt       = S_CHUNK;
`endif
        end
      end
`ifdef SLICE_MUX_PPS_EN
      S_PPS: begin
        out_valid = 1'b1;
        emit      = out_ready;
        if (emit) begin
          pps_nxt     = {256'd0, pps_q[1023:256]};
          pps_cnt_nxt = pps_cnt + 2'd1;
          if (pps_cnt == 2'd3) begin
            state_nxt   = S_CHUNK;
            acc_cnt_nxt = '0;
          end
        end
      end
`endif
      S_CHUNK: begin
        out_valid   = (acc_cnt >= 7'd32);
        emit        = out_valid & out_ready;
        in_rdy      = !out_valid | out_ready;
        accept      = in_rdy & sel_valid;
        acc_sh      = emit ? {256'd0, acc[511:256]} : acc;
        cnt_sh      = emit ? (acc_cnt - 7'd32) : acc_cnt;
        // cnt_sh is below 32 whenever a word is accepted, so 5 bits index the byte slot.
        ins         = ABITS'(sel_word & mask) << {cnt_sh[4:0], 3'b000};
        acc_nxt     = accept ? (acc_sh | ins) : acc_sh;
        acc_cnt_nxt = accept ? (cnt_sh + 7'(n)) : cnt_sh;
        if (accept) begin
          if (bytes_left == 16'(n)) begin
            bytes_left_nxt = chunk_size;
            if (10'(active) + 10'd1 == slices_per_line) begin
              active_nxt = '0;
              if (chunk_idx + 16'd1 == chunks_per_slice) state_nxt = S_TAIL;
              else chunk_idx_nxt = chunk_idx + 16'd1;
            end else begin
              active_nxt = active + AW'(1);
            end
          end else begin
            bytes_left_nxt = bytes_left - 16'(n);
          end
        end
      end
      S_TAIL: begin
        out_valid = (acc_cnt != 7'd0);
        out_last  = out_valid && (acc_cnt <= 7'd32);
        emit      = out_valid & out_ready;
        if (emit) begin
          acc_nxt = {256'd0, acc[511:256]};
          if (out_last) begin
            state_nxt   = S_IDLE;
            acc_cnt_nxt = '0;
          end else begin
            acc_cnt_nxt = acc_cnt - 7'd32;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (emit) sof_pending_nxt = 1'b0;
  end

  // Only the active slice may see ready.
  always_comb begin
    in_ready = '0;
    for (int s = 0; s < int'(MAX_NBR_SLICES); s++) begin
      in_ready[s] = in_rdy && (active == AW'(s));
    end
  end

  assign out_sof = out_valid & sof_pending;

`ifdef SLICE_MUX_PPS_EN
  assign out_data        = (state == S_PPS) ? pps_q[255:0] : acc[255:0];
  assign data_out_is_pps = (state == S_PPS);
`else
  assign out_data        = acc[255:0];
  assign data_out_is_pps = 1'b0;
`endif

endmodule

// File: doc/slice_mux.md
Name: slice_mux

Overview:
- Encoder-side counterpart of the decoder slice demultiplexer.
- Accepts per-slice chunk streams from MAX_NBR_SLICES slice encoders and interleaves them round-robin: chunk k of slice 0, slice 1 … slice N-1, then chunk k+1.
- Packs all chunks byte-contiguously into a single 256-bit rate-buffer/output stream, with no padding between chunks.
- Pads only the final word of a frame with zero bytes.

Parameters:
- MAX_NBR_SLICES, 2, maximum slices per line; sets port widths.
- MAX_SLICE_WIDTH, 2560, informational only; not used in datapath sizing.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous abort to IDLE.
- slices_per_line  input  10  active slice count, legal range 1..MAX_NBR_SLICES.
- chunk_size  input  16  bytes per chunk, legal range ≥1.
- chunks_per_slice  input  16  chunks per slice per frame, legal range ≥1.
- frame_start  input  1  one-cycle pulse; starts a frame.
- in_data_p  input  256*MAX_NBR_SLICES  per-slice word; slice s occupies [s*256+:256].
- in_valid  input  MAX_NBR_SLICES  per-slice valid.
- in_ready  output  MAX_NBR_SLICES  per-slice ready.
- in_pps  input  1024  128-byte PPS; used only with the macro.
- out_data  output  256  packed output word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream ready.
- out_sof  output  1  high on the first word of a frame.
- out_last  output  1  high on the word carrying the final frame byte.
- data_out_is_pps  output  1  current word is PPS.

Behaviour:
- Byte order: byte k of any word is bits [8k+7:8k]; the earliest byte is at k=0.
- Chunk word format: each chunk arrives as ceil(chunk_size/32) words. The last word carries chunk_size-32*(W-1) valid bytes in its low bytes; its upper bytes are discarded.
- Transfer rule: a transfer occurs on valid&ready, independently on each side.
- Reset (rst_n=0 at clk edge):
  - state=IDLE; acc_cnt=0; accumulator=0.
  - out_valid=0, out_sof=0, out_last=0, data_out_is_pps=0, out_data=0, in_ready=0.
- flush: same effect as reset, except the accumulator contents are don't-care. flush wins over a simultaneous frame_start.
- Accumulator: 512-bit register acc, byte count acc_cnt (7 bits, range 0..63). out_data is acc[255:0].
- States: IDLE, PPS (macro only), CHUNK, TAIL.
- IDLE:
  - in_ready=0, out_valid=0.
  - frame_start with slices_per_line in 1..MAX_NBR_SLICES, chunk_size≥1 and chunks_per_slice≥1 moves to PPS (if enabled) or CHUNK.
  - Load active=0, chunk_idx=0, bytes_left=chunk_size, sof_pending=1.
  - An illegal configuration ignores frame_start and stays in IDLE.
  - frame_start outside IDLE is ignored.
- CHUNK:
  - Only in_ready[active] can be 1; all other bits are 0.
  - emit = out_valid & out_ready, where out_valid = (acc_cnt≥32).
  - in_ready[active] = (acc_cnt<32) | emit. This is combinational from out_ready.
  - Accepted word: n = min(32, bytes_left) bytes are appended at byte position acc_cnt (after the emit shift, when emit occurs in the same cycle).
  - Per accept: bytes_left -= n.
  - When bytes_left reaches 0:
    - active = (active+1 == slices_per_line) ? 0 : active+1.
    - bytes_left reloads to chunk_size.
    - chunk_idx increments on wrap to slice 0.
  - After the last chunk of the last slice is accepted, go to TAIL.
  - acc_cnt next value = acc_cnt - 32·emit + n·accept. Emit shifts acc right by 256 bits.
- TAIL:
  - in_ready=0; out_valid = (acc_cnt>0).
  - out_last = out_valid & (acc_cnt≤32).
  - Bytes at position acc_cnt and above are 0.
  - Go to IDLE on the emit where out_last is high.
- out_sof = out_valid & sof_pending. sof_pending clears on the first emit.
- Outputs must hold stable while out_valid=1 and out_ready=0.
- Latency: a word accepted at edge t is visible on out_data from cycle t+1, once acc_cnt≥32.
- Sustained throughput: one word per cycle with chunk_size a multiple of 32 and out_ready=1.
- Counter widths:
  - bytes_left: 16 bits.
  - chunk_idx: 16 bits.
  - active: $clog2(MAX_NBR_SLICES) bits, minimum 1.
- Configuration inputs are sampled continuously; they must be held constant from frame_start until out_last.

Optional Feature:
- Macro SLICE_MUX_PPS_EN.
- Defined:
  - After frame_start, the PPS state emits in_pps as 4 words, bytes 0..127 in order; in_pps is sampled at frame_start.
  - data_out_is_pps=1 on those 4 words; out_sof is on PPS word 0.
  - Then go to CHUNK with acc_cnt=0.
- Undefined:
  - No PPS state; in_pps is ignored.
  - data_out_is_pps is constant 0.

Test Plan:
- Interleave order:
  - Setup: slices=2, chunk_size=32, chunks_per_slice=2.
  - Stimulus: slice0 words A0,A1; slice1 words B0,B1.
  - Required response: output A0,B0,A1,B1; out_sof on A0; out_last on B1.
- Byte packing:
  - Setup: slices=2, chunk_size=40, chunks_per_slice=1.
  - Stimulus: slice0 bytes 0x00..0x27; slice1 bytes 0x80..0xA7.
  - Required response: 3 words: [00..1F], [20..27,80..97], [98..A7,16×00]; out_last on word 2.
- Backpressure:
  - Stimulus: test 2 with out_ready=0 for 10 cycles after the first word.
  - Required response: in_ready deasserts while acc_cnt≥32; identical byte sequence; no duplicates.
- Illegal configuration:
  - Stimulus: frame_start with slices_per_line=0, then with chunk_size=0.
  - Required response: state stays IDLE; in_ready=0; out_valid=0.
- Abort and reset:
  - Stimulus: flush mid-frame, then a new frame.
  - Required response: out_valid=0 the next cycle; the new frame is output correctly.
  - Stimulus: rst_n=0 mid-frame.
  - Required response: all outputs 0 at the next edge.
- PPS (SLICE_MUX_PPS_EN):
  - Stimulus: test 1 with the macro defined.
  - Required response: 4 PPS words with data_out_is_pps=1 and out_sof on PPS word 0, then A0,B0,A1,B1 with data_out_is_pps=0.
